// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle; start/busy/done handshake for the pipeline controller.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Signed operands become magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign a_mag = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

  // Multiply keeps the multiplier in acc low half and shifts the partial product in from the top.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide shifts dividend bits out of acc low half and shifts quotient bits back in.
  assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod_fix = neg_q     ? -acc_q              : acc_q;
  assign quo_fix  = neg_q     ? -acc_q[WIDTH-1:0]   : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -rem_q[WIDTH-1:0]   : rem_q[WIDTH-1:0];

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (op[1] && src_b == '0) begin
            hi_d    = src_a;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d   = RUN;
            cnt_d     = '0;
            dbz_d     = 1'b0;
            is_div_d  = op[1];
            neg_d     = op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            rem_neg_d = op[0] & src_a[WIDTH-1];
            rem_d     = '0;
            if (op[1]) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
          end
        end else begin
          if (hi_we) hi_d = src_a;
          if (lo_we) lo_d = src_a;
        end
      end
      RUN: begin
        if (is_div_q) begin
          rem_d = div_ge ? div_diff : div_shift;
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a cycle-count reference model compared every cycle,
// plus directed literal checks and randomized operations.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference result straight from integer arithmetic: {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    case (o)
      2'b00: p = {32'b0, a} * {32'b0, b};
      2'b01: begin sa = longint'($signed(a)); sb = longint'($signed(b)); p = sa * sb; end
      2'b10: p = {a % b, a / b};
      default: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
    endcase
    return p;
  endfunction

  // Model: an accepted op keeps the unit busy for W+1 cycles, then results land with done.
  int           m_rem = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic         m_dbz = 1'b0, m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_hi <= '0; m_lo <= '0; m_dbz <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (start) begin
          if (op[1] && src_b == 0) begin
            m_hi <= src_a; m_lo <= '1; m_dbz <= 1'b1; m_done <= 1'b1;
          end else begin
            m_rem <= W + 1;
            {m_phi, m_plo} <= ref_result(op, src_a, src_b);
            m_dbz <= 1'b0;
          end
        end else begin
          if (hi_we) m_hi <= src_a;
          if (lo_we) m_lo <= src_a;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi <= m_phi; m_lo <= m_plo; m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_rem != 0);
      check("done", done, m_done);
      check("div_by_zero", div_by_zero, m_dbz);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_done(input int max, output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (!done && lat < max) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1'b1);
  endtask

  initial begin
    int lat, nb;
    bit saw_done;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #2;
    check("rst_hi", hi, 0); check("rst_lo", lo, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_dbz", div_by_zero, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(100, lat, nb);
    check("multu_latency", lat, 33); check("multu_busy_cycles", nb, 33);
    check("multu_hi", hi, 32'hFFFF_FFFE); check("multu_lo", lo, 32'h0000_0001);

    do_op(2'b01, 32'hFFFF_FFFD, 32'd5);
    wait_done(100, lat, nb);
    check("mult_hi", hi, 32'hFFFF_FFFF); check("mult_lo", lo, 32'hFFFF_FFF1);

    do_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done(100, lat, nb);
    check("div_lo", lo, 32'hFFFF_FFFD); check("div_hi", hi, 32'hFFFF_FFFF);

    do_op(2'b10, 32'd100, 32'd7);
    wait_done(100, lat, nb);
    check("divu_lo", lo, 32'd14); check("divu_hi", hi, 32'd2);

    do_op(2'b10, 32'h1234, 32'h0);
    wait_done(100, lat, nb);
    check("dbz_latency", lat, 0); check("dbz_flag", div_by_zero, 1);
    check("dbz_hi", hi, 32'h1234); check("dbz_lo", lo, 32'hFFFF_FFFF);
    do_op(2'b00, 32'd2, 32'd3);
    check("dbz_cleared", div_by_zero, 0);
    wait_done(100, lat, nb);

    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(100, lat, nb);
    check("ovf_lo", lo, 32'h8000_0000); check("ovf_hi", hi, 32'h0); check("ovf_dbz", div_by_zero, 0);

    // Start and MTHI while busy must be ignored.
    do_op(2'b00, 32'd12345, 32'd678);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd999; src_b = 32'd3; hi_we = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done(100, lat, nb);
    check("ignore_lo", lo, 32'd8369910); check("ignore_hi", hi, 32'd0);

    // Back-to-back from DONE: no IDLE cycle in between.
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done(100, lat, nb);
    check("b2b_lo", lo, 32'd333); check("b2b_hi", hi, 32'd1);

    @(negedge clk);
    hi_we = 1'b1; src_a = 32'hCAFE_BABE;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", hi, 32'hCAFE_BABE); check("mthi_lo_kept", lo, 32'd333);

    // Start wins over a simultaneous MTHI/MTLO.
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_done(100, lat, nb);
    check("start_wins_lo", lo, 32'd81); check("start_wins_hi", hi, 32'd0);

    // Asynchronous reset mid-operation.
    do_op(2'b01, 32'hFFFE_7960, 32'd77777);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 0); check("arst_lo", lo, 0);
    check("arst_busy", busy, 0); check("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_reset", saw_done, 0);
    do_op(2'b00, 32'd6, 32'd7);
    wait_done(100, lat, nb);
    check("post_rst_lo", lo, 32'd42); check("post_rst_hi", hi, 32'd0);

    // Randomized operations with disturbances; the per-cycle compare does the checking.
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: rb = $urandom_range(1, 20);
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op(ro, ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        start = 1'b1; hi_we = 1'($urandom); lo_we = 1'($urandom);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      wait_done(100, lat, nb);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        hi_we = 1'($urandom); lo_we = 1'($urandom); src_a = $urandom;
      end
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage beside the ALU. It takes the same src_a/src_b operands from the register-file/immediate muxes.
- HI/LO feed the writeback mux for MFHI/MFLO.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with a start/busy/done handshake, so the controller can stall while an operation runs.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an operation; sampled on a clock edge
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- src_a  input  WIDTH  multiplicand/dividend; data source for MTHI/MTLO
- src_b  input  WIDTH  multiplier/divisor
- hi_we  input  1  MTHI: write src_a into HI
- lo_we  input  1  MTLO: write src_a into LO
- busy  output  1  operation in progress; controller must stall MFHI/MFLO/start
- done  output  1  one-cycle pulse: HI/LO hold the new result
- div_by_zero  output  1  last division had src_b == 0; valid from done onward
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset:
  - Asynchronous; effective at any time, including mid-operation.
  - Clears to: state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, internal counter/accumulators=0.
  - An in-flight operation is abandoned with no HI/LO update.
- States: IDLE, RUN, FIX, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE.
  - The accepting edge latches op, src_a and src_b. Operand changes afterwards are ignored.
  - The same edge clears div_by_zero and enters RUN with counter=0.
  - start is ignored in RUN and FIX.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at accept. -2^(WIDTH-1) maps to an unsigned magnitude of 2^(WIDTH-1).
  - Result signs are recorded: product sign = a^b; quotient sign = a^b; remainder sign = sign of a.
- RUN:
  - Exactly WIDTH cycles, one bit per cycle.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; partial remainder WIDTH+1 bits.
  - Counter reaches WIDTH-1, then the next edge goes to FIX.
- FIX:
  - One cycle. Applies two's-complement sign correction.
  - Multiply: {hi,lo} = 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder, both truncated to WIDTH.
  - DIV 0x80000000 / 0xFFFFFFFF wraps to lo=0x80000000, hi=0 and is not flagged.
  - Next edge: DONE.
- Division by zero:
  - DIV/DIVU with src_b == 0 at accept goes straight to DONE, skipping RUN and FIX.
  - Writes hi=src_a, lo=all ones and sets div_by_zero=1.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Next edge returns to IDLE, or to RUN if start is accepted (back-to-back ops).
- busy: 1 in RUN and FIX only. Deasserts on the same edge that raises done.
- Latency: accept edge E.
  - Normal op: done high in the cycle after edge E+WIDTH+1 (WIDTH+1 edges after acceptance).
  - Divide by zero: done high in the cycle after edge E.
- MTHI/MTLO:
  - Honoured in IDLE/DONE only; takes effect on the next edge.
  - hi_we and lo_we together write src_a into both registers.
  - Ignored while busy.
  - If start is accepted on the same edge, start wins and the write is dropped.
- HI/LO hold their value at all times except on writes from FIX, the divide-by-zero path, MTHI/MTLO, or reset.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → busy high for 33 cycles. done exactly 33 edges after accept, hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2.
- DIVU 0x1234 / 0 → done on the cycle after accept, div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF. Next accepted start clears div_by_zero.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- Handshake:
  - start pulsed at cycle 5 of RUN with different operands → ignored; result matches the first op.
  - start during DONE → new op runs immediately, no IDLE cycle.
  - hi_we during busy → HI unchanged; hi_we in IDLE with src_a=0xCAFEBABE → hi=0xCAFEBABE.
- Reset: rst_n dropped asynchronously 10 cycles into a MULT → hi=lo=0 and busy=done=0 immediately. No done after release; a new MULTU 6×7 then completes with lo=42, hi=0.
